poly_accumulator: RTL and testbench

// Receiving end of the partial-product stream from the public/private multiplier.
// - Each B beat carries 7 partial-product coefficients (6 bits each) and a base index.
// - Adds them mod 64 into a DEPTH-coefficient polynomial held in registers.
// - After NUM_PRODUCTS beats, streams the finished polynomial out 4 coefficients per beat
//   (same 24-bit packing as pk_A), then re-arms for the next product.

---
 rtl/poly_accumulator_if.sv | 26 ++
 rtl/poly_accumulator.sv | 123 ++++++++++++
 tb/tb_poly_accumulator.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/poly_accumulator_if.sv
// Bus bundle for poly_accumulator: partial-product beat input, clear,
// and the valid/ready coefficient output stream.
interface poly_accumulator_if;
   logic        B_valid;
   logic [9:0]  idx_B;
   logic [41:0] B_out;
   logic        clear_in;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_idx;
   logic [23:0] out_data;
   logic        out_last;
   logic        err_out;

   // Producer/consumer side: drives beats and ready, observes the stream.
   modport master (
      output B_valid, idx_B, B_out, clear_in, out_ready,
      input  out_valid, out_idx, out_data, out_last, err_out
   );

   // Accumulator side.
   modport slave (
      input  B_valid, idx_B, B_out, clear_in, out_ready,
      output out_valid, out_idx, out_data, out_last, err_out
   );
endinterface

// File: rtl/poly_accumulator.sv
// Polynomial accumulator: folds 7-coefficient partial-product beats into a
// DEPTH-coefficient mod-64 polynomial, then drains it 4 coefficients per beat.
module poly_accumulator #(
   parameter int unsigned DEPTH        = 784,
   parameter int unsigned NUM_PRODUCTS = 38416,
   parameter bit          NEGACYCLIC   = 1'b1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   poly_accumulator_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned SW = ((AW > 10) ? AW : 10) + 1;
   localparam logic [7:0]       LAST_IDX = 8'(DEPTH / 4 - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PRODUCTS - 1);

   typedef enum logic {ST_ACCUM, ST_DRAIN} state_t;

   state_t           r_state, w_next;
   logic [5:0]       r_coef [DEPTH];
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_idx;
   logic             r_err;

   logic [SW-1:0]    w_sum  [7];
   logic [6:0]       w_wrap;
   logic [AW-1:0]    w_pos  [7];
   logic [5:0]       w_term [7];
   logic [AW-1:0]    w_rd   [4];
   logic             w_accept, w_xfer, w_last, w_drop;

   assign w_accept = (r_state == ST_ACCUM) && bus.B_valid && !bus.clear_in;
   assign w_drop   = (r_state == ST_DRAIN) && bus.B_valid && !bus.clear_in;
   assign w_xfer   = (r_state == ST_DRAIN) && bus.out_ready && !bus.clear_in;
   assign w_last   = (r_idx == LAST_IDX);

   // Target index and signed term for each of the 7 incoming coefficients.
   // The 7 indices of one beat are always distinct, so each register sees
   // at most one term per cycle.
   always_comb begin
      w_sum  = '{default: '0};
      w_pos  = '{default: '0};
      w_term = '{default: '0};
      w_wrap = '0;
      for (int unsigned k = 0; k < 7; k++) begin
         w_sum[k]  = SW'(bus.idx_B) + SW'(k);
         w_wrap[k] = (w_sum[k] >= SW'(DEPTH));
         w_pos[k]  = w_wrap[k] ? AW'(w_sum[k] - SW'(DEPTH)) : AW'(w_sum[k]);
         w_term[k] = (w_wrap[k] && NEGACYCLIC) ? (6'd0 - bus.B_out[6*k +: 6])
                                               : bus.B_out[6*k +: 6];
      end
   end

   // Coefficient addresses of the output beat currently presented.
   always_comb begin
      w_rd = '{default: '0};
      for (int unsigned j = 0; j < 4; j++) begin
         w_rd[j] = AW'({r_idx, 2'(j)});
      end
   end

   // State register.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) r_state <= ST_ACCUM;
      else         r_state <= w_next;
   end

   // Next state: last beat of a product opens DRAIN, last transfer closes it.
   always_comb begin
      w_next = r_state;
      if (bus.clear_in) begin
         w_next = ST_ACCUM;
      end else begin
         case (r_state)
            ST_ACCUM: if (w_accept && (r_cnt == LAST_CNT)) w_next = ST_DRAIN;
            ST_DRAIN: if (w_xfer && w_last)                 w_next = ST_ACCUM;
            default:                                        w_next = ST_ACCUM;
         endcase
      end
   end

   // Coefficient array, beat counter, drain index and sticky error.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_coef[i] <= '0;
         r_cnt <= '0;
         r_idx <= '0;
         r_err <= 1'b0;
      end else if (bus.clear_in) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_coef[i] <= '0;
         r_cnt <= '0;
         r_idx <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            for (int unsigned k = 0; k < 7; k++) begin
               r_coef[w_pos[k]] <= r_coef[w_pos[k]] + w_term[k];
            end
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_drop) r_err <= 1'b1;
         if (w_xfer) begin
            // Zeroing on transfer leaves the array clean for the next product.
            for (int unsigned j = 0; j < 4; j++) r_coef[w_rd[j]] <= '0;
            if (w_last) begin
               r_idx <= '0;
               r_cnt <= '0;
            end else begin
               r_idx <= r_idx + 1'b1;
            end
         end
      end
   end

   assign bus.out_valid = (r_state == ST_DRAIN);
   assign bus.out_idx   = r_idx;
   assign bus.out_last  = bus.out_valid && w_last;
   assign bus.out_data  = bus.out_valid ? {r_coef[w_rd[3]], r_coef[w_rd[2]],
                                           r_coef[w_rd[1]], r_coef[w_rd[0]]}
                                        : '0;
   assign bus.err_out   = r_err;
endmodule

// File: tb/tb_poly_accumulator.sv
// Randomised bench for poly_accumulator: one negacyclic and one cyclic
// instance share stimulus and are checked against an array-based model.
module tb_poly_accumulator;
   localparam int unsigned DEPTH = 784;
   localparam int unsigned NP    = 4;
   localparam int unsigned NB    = DEPTH / 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        b_valid;
   logic [9:0]  idx_b;
   logic [41:0] b_out;
   logic        clr;
   logic        rdy;

   int unsigned n_err = 0;
   int unsigned n_chk = 0;

   int unsigned m_n [DEPTH];
   int unsigned m_c [DEPTH];
   int unsigned m_beats;
   int unsigned m_oidx;
   bit          m_drain;
   bit          m_err;

   poly_accumulator_if if_n ();
   poly_accumulator_if if_c ();

   assign if_n.B_valid   = b_valid;
   assign if_n.idx_B     = idx_b;
   assign if_n.B_out     = b_out;
   assign if_n.clear_in  = clr;
   assign if_n.out_ready = rdy;
   assign if_c.B_valid   = b_valid;
   assign if_c.idx_B     = idx_b;
   assign if_c.B_out     = b_out;
   assign if_c.clear_in  = clr;
   assign if_c.out_ready = rdy;

   poly_accumulator #(.DEPTH(DEPTH), .NUM_PRODUCTS(NP), .NEGACYCLIC(1'b1), .CNT_W(16))
      u_dut_n (.clk_in(clk), .rst_in(rst_n), .bus(if_n));
   poly_accumulator #(.DEPTH(DEPTH), .NUM_PRODUCTS(NP), .NEGACYCLIC(1'b0), .CNT_W(16))
      u_dut_c (.clk_in(clk), .rst_in(rst_n), .bus(if_c));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic m_clear();
      for (int i = 0; i < int'(DEPTH); i++) begin
         m_n[i] = 0;
         m_c[i] = 0;
      end
      m_beats = 0;
      m_oidx  = 0;
      m_drain = 0;
      m_err   = 0;
   endtask

   function automatic logic [23:0] exp_word(input bit neg, input int unsigned b);
      logic [23:0] w;
      w = '0;
      for (int j = 0; j < 4; j++)
         w[6*j +: 6] = 6'(neg ? m_n[4*b + j] : m_c[4*b + j]);
      return w;
   endfunction

   task automatic check_outs(input string tag);
      chk({tag, "_vld_n"},  64'(if_n.out_valid), 64'(m_drain));
      chk({tag, "_vld_c"},  64'(if_c.out_valid), 64'(m_drain));
      chk({tag, "_err_n"},  64'(if_n.err_out),   64'(m_err));
      chk({tag, "_err_c"},  64'(if_c.err_out),   64'(m_err));
      chk({tag, "_idx_n"},  64'(if_n.out_idx),   64'(m_oidx));
      chk({tag, "_last_n"}, 64'(if_n.out_last),  64'(m_drain && m_oidx == NB - 1));
      chk({tag, "_last_c"}, 64'(if_c.out_last),  64'(m_drain && m_oidx == NB - 1));
      chk({tag, "_dat_n"},  64'(if_n.out_data),  64'(m_drain ? exp_word(1'b1, m_oidx) : 24'd0));
      chk({tag, "_dat_c"},  64'(if_c.out_data),  64'(m_drain ? exp_word(1'b0, m_oidx) : 24'd0));
   endtask

   task automatic send(input logic [9:0] idx, input logic [41:0] co);
      int unsigned p, c;
      bit wrap;
      b_valid = 1'b1;
      idx_b   = idx;
      b_out   = co;
      @(posedge clk); #1;
      b_valid = 1'b0;
      if (m_drain) begin
         m_err = 1;
      end else begin
         for (int k = 0; k < 7; k++) begin
            p    = int'(idx) + k;
            wrap = (p >= DEPTH);
            if (wrap) p = p - DEPTH;
            c = int'(co[6*k +: 6]);
            m_n[p] = (m_n[p] + (wrap ? (64 - c) % 64 : c)) % 64;
            m_c[p] = (m_c[p] + c) % 64;
         end
         m_beats++;
         if (m_beats == NP) begin
            m_drain = 1;
            m_oidx  = 0;
         end
      end
      check_outs("beat");
   endtask

   function automatic logic [41:0] rand_co();
      return {10'($urandom), $urandom};
   endfunction

   task automatic send_rand_product();
      for (int i = 0; i < int'(NP); i++) send(10'($urandom_range(0, 1023)), rand_co());
   endtask

   task automatic do_clear(input bit with_beat);
      clr     = 1'b1;
      b_valid = with_beat;
      idx_b   = 10'($urandom_range(0, 1023));
      b_out   = rand_co();
      @(posedge clk); #1;
      clr     = 1'b0;
      b_valid = 1'b0;
      m_clear();
      check_outs("clr");
   endtask

   // Drain the whole product; negative positions disable hold/error/reset events.
   task automatic drain(input int stall_pct, input int hold_at, input int err_at, input int rst_at);
      int n_hold;
      for (int b = 0; b < int'(NB); b++) begin
         if (b == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_vld_n", 64'(if_n.out_valid), 64'd0);
            chk("rst_vld_c", 64'(if_c.out_valid), 64'd0);
            chk("rst_idx_n", 64'(if_n.out_idx),   64'd0);
            m_clear();
            @(posedge clk); #1;
            rst_n = 1'b1;
            check_outs("rst");
            return;
         end
         check_outs("drn");
         if (b == hold_at) n_hold = 5;
         else n_hold = ($urandom_range(0, 99) < stall_pct) ? int'($urandom_range(1, 3)) : 0;
         for (int h = 0; h < n_hold; h++) begin
            rdy = 1'b0;
            @(posedge clk); #1;
            check_outs("hold");
         end
         if (b == err_at) begin
            rdy     = 1'b0;
            b_valid = 1'b1;
            idx_b   = 10'($urandom_range(0, 1023));
            b_out   = rand_co();
            @(posedge clk); #1;
            b_valid = 1'b0;
            m_err   = 1;
            check_outs("errp");
         end
         rdy = 1'b1;
         @(posedge clk); #1;
         rdy = 1'b0;
         for (int j = 0; j < 4; j++) begin
            m_n[4*b + j] = 0;
            m_c[4*b + j] = 0;
         end
         m_oidx++;
         if (m_oidx == NB) begin
            m_drain = 0;
            m_oidx  = 0;
            m_beats = 0;
         end
      end
      check_outs("post");
   endtask

   initial begin
      logic [41:0] co;
      rst_n   = 1'b0;
      b_valid = 1'b0;
      idx_b   = '0;
      b_out   = '0;
      clr     = 1'b0;
      rdy     = 1'b0;
      m_clear();
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset");
      rst_n = 1'b1;

      // Coefficients 1..7 at index 0.
      for (int k = 0; k < 7; k++) co[6*k +: 6] = 6'(k + 1);
      send(10'd0, co);
      for (int i = 1; i < int'(NP); i++) send(10'd500, '0);
      chk("t1_beat0_n", 64'(if_n.out_data), 64'h103081);
      drain(0, -1, -1, -1);

      // Wrap at index 780 with all-ones; 5-cycle hold at beat 3.
      for (int k = 0; k < 7; k++) co[6*k +: 6] = 6'd1;
      send(10'd780, co);
      for (int i = 1; i < int'(NP); i++) send(10'd10, '0);
      chk("t2_wrap_n", 64'(if_n.out_data), 64'h03FFFF);
      chk("t2_wrap_c", 64'(if_c.out_data), 64'h001041);
      drain(20, 3, -1, -1);

      // Back-to-back overlap, mod-64 carry; error pulse during drain.
      for (int k = 0; k < 7; k++) co[6*k +: 6] = 6'd40;
      send(10'd0, co);
      send(10'd1, co);
      for (int i = 2; i < int'(NP); i++) send(10'd300, '0);
      chk("t3_ovl_n", 64'(if_n.out_data), 64'h410428);
      drain(10, -1, 10, -1);
      chk("t3_err_n", 64'(if_n.err_out), 64'd1);
      do_clear(1'b0);

      // Clear colliding with a beat mid-accumulation.
      send(10'($urandom_range(0, 1023)), rand_co());
      send(10'($urandom_range(0, 1023)), rand_co());
      do_clear(1'b1);
      send_rand_product();
      drain(30, -1, -1, -1);

      // Reset mid-drain, then a fresh product.
      send_rand_product();
      drain(0, -1, -1, 50);
      send_rand_product();
      drain(25, -1, -1, -1);

      for (int r = 0; r < 3; r++) begin
         send_rand_product();
         drain(15, -1, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
